// File: rtl/core_seq.sv
// Multi-cycle fetch/execute sequencer: 2+ cycles per instruction, halts at last_pc, faults on fetch timeout.
// Optional CORE_SEQ_PERF_CNT_EN adds cycle_cnt/instret counters.
module core_seq #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] last_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        ctl_rf_we,
    output logic        rf_we,
    output logic        retire,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault
`ifdef CORE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
`endif
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [15:0] TMO_LAST = 16'(FETCH_TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            instr   <= NOP;
            tmo_cnt <= 16'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (imem_ack) begin
                        instr   <= imem_rdata;
                        tmo_cnt <= 16'd0;
                        state   <= S_EXEC;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= S_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (pc == last_pc) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= pc + 32'd1;
                        state <= S_FETCH;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // State resets to FETCH asynchronously, so the request is masked while reset is held.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;
    assign retire    = (state == S_EXEC);
    assign rf_we     = (state == S_EXEC) && ctl_rf_we;
    assign halted    = (state == S_HALT);
    assign fault     = (state == S_FAULT);

`ifdef CORE_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instret   <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: normal program, delayed acks, timeout fault, pc wrap, reset abort.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] last_pc = 32'd3;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        ctl_rf_we = 1'b1;
    logic        rf_we, retire, halted, fault;
    logic [31:0] pc;

    logic        w_req, w_rf_we, w_retire, w_halted, w_fault;
    logic [31:0] w_addr, w_instr, w_pc, w_rdata;

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret, w_cycle_cnt, w_instret;
`endif

    logic ack_en    = 1'b1;
    logic force_ack = 1'b0;
    int   ack_delay = 0;
    int   wait_cnt;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    assign imem_ack   = force_ack | (imem_req & ack_en & (wait_cnt >= ack_delay));
    assign imem_rdata = rd(imem_addr);
    assign w_rdata    = 32'hC0DE_0000 ^ w_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    core_seq #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .last_pc(last_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .ctl_rf_we(ctl_rf_we),
        .rf_we(rf_we), .retire(retire), .pc(pc), .halted(halted), .fault(fault)
`ifdef CORE_SEQ_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
    );

    core_seq #(.RESET_PC(32'hFFFF_FFFF), .FETCH_TIMEOUT(16)) u_wrap (
        .clk(clk), .rst(rst), .last_pc(32'h0000_0000),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req),
        .imem_rdata(w_rdata), .instr(w_instr), .ctl_rf_we(1'b1),
        .rf_we(w_rf_we), .retire(w_retire), .pc(w_pc), .halted(w_halted), .fault(w_fault)
`ifdef CORE_SEQ_PERF_CNT_EN
        , .cycle_cnt(w_cycle_cnt), .instret(w_instret)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds reset for two cycles, checks reset values, releases just after a negedge
    // and samples cycle 1 (first FETCH cycle).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_flags", {28'd0, rf_we, retire, halted, fault}, 32'd0);
`ifdef CORE_SEQ_PERF_CNT_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instret", instret, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Program 0..3, ack in the same cycle as req, rf write enable tied high.
        last_pc = 32'd3; ack_en = 1'b1; ack_delay = 0; ctl_rf_we = 1'b1;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            automatic logic        req_e = (c % 2 == 1) && (c <= 7);
            automatic logic        ret_e = (c % 2 == 0) && (c <= 8);
            automatic logic [31:0] pc_e  = (c <= 8) ? 32'((c - 1) / 2) : 32'd3;
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            chk("p1_req", {31'd0, imem_req}, {31'd0, req_e});
            chk("p1_retire", {31'd0, retire}, {31'd0, ret_e});
            chk("p1_rf_we", {31'd0, rf_we}, {31'd0, ret_e});
            chk("p1_pc", pc, pc_e);
            chk("p1_halted", {31'd0, halted}, {31'd0, (c >= 9)});
            if (ret_e) chk("p1_instr", instr, rd(pc_e));
            if (c <= 6) begin
                chk("wrap_pc", w_pc, (c <= 2) ? 32'hFFFF_FFFF : 32'd0);
                chk("wrap_retire", {31'd0, w_retire}, {31'd0, (c == 2 || c == 4)});
                chk("wrap_halted", {31'd0, w_halted}, {31'd0, (c >= 5)});
            end
`ifdef CORE_SEQ_PERF_CNT_EN
            if (c == 9) begin
                chk("p1_cycle_cnt", cycle_cnt, 32'd8);
                chk("p1_instret", instret, 32'd4);
            end
`endif
        end

        // Ack delayed 3 cycles: 4 FETCH cycles + 1 EXEC per instruction.
        last_pc = 32'd1; ack_delay = 3; ctl_rf_we = 1'b0;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            automatic int ph  = (c - 1) % 5;
            automatic int ins = (c - 1) / 5;
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            chk("p2_rf_we", {31'd0, rf_we}, 32'd0);
            if (c <= 10) begin
                chk("p2_req", {31'd0, imem_req}, {31'd0, (ph < 4)});
                chk("p2_addr", imem_addr, 32'(ins));
                chk("p2_retire", {31'd0, retire}, {31'd0, (ph == 4)});
                if (ph == 4) chk("p2_instr", instr, rd(32'(ins)));
                if (c >= 6 && c <= 9) chk("p2_instr_hold", instr, rd(32'd0));
            end else begin
                chk("p2_halt_req", {31'd0, imem_req}, 32'd0);
                chk("p2_halted", {31'd0, halted}, 32'd1);
                chk("p2_halt_pc", pc, 32'd1);
            end
        end

        // Memory never answers: fault after exactly 16 FETCH cycles.
        ack_en = 1'b0; ctl_rf_we = 1'b1; last_pc = 32'd7;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            chk("to_req", {31'd0, imem_req}, {31'd0, (c <= 16)});
            chk("to_fault", {31'd0, fault}, {31'd0, (c >= 17)});
            chk("to_we_ret", {30'd0, rf_we, retire}, 32'd0);
            chk("to_pc", pc, 32'd0);
        end

        // Reset asserted mid-FETCH while ack is high.
        ack_en = 1'b1; ack_delay = 0; last_pc = 32'd5;
        do_reset();
        @(negedge clk); @(negedge clk);
        #1;
        chk("ab_pre_pc", pc, 32'd1);
        chk("ab_pre_instr", instr, rd(32'd0));
        force_ack = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("ab_req", {31'd0, imem_req}, 32'd0);
        chk("ab_instr", instr, 32'h0000_0013);
        chk("ab_pc", pc, 32'd0);
        @(posedge clk);
        #1;
        chk("ab_post_instr", instr, 32'h0000_0013);
        chk("ab_post_we", {30'd0, rf_we, retire}, 32'd0);
`ifdef CORE_SEQ_PERF_CNT_EN
        chk("ab_cycle_cnt", cycle_cnt, 32'd0);
        chk("ab_instret", instret, 32'd0);
`endif
        force_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the CPU core datapath (pc, reg_file, alu, control).
- Fetches one instruction per step over a req/ack instruction-memory handshake and latches it into an instruction register for decode.
- Gates the decoder's register-file write enable to a single execute cycle.
- Advances pc, stops at a programmed last address, and faults if memory never answers.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset (word address).
- FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before FAULT; legal range 1..65535.

Ports:
- clk  in  1  core clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- last_pc  in  32  word address of final instruction; sequencer halts after executing it.
- imem_req  out  1  fetch request, high only in FETCH.
- imem_addr  out  32  fetch word address, equals pc.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction register, to control/reg_file decode.
- ctl_rf_we  in  1  raw write enable from decoder.
- rf_we  out  1  gated register-file write enable.
- retire  out  1  one-cycle pulse per executed instruction.
- pc  out  32  current instruction word address.
- halted  out  1  sticky halt flag.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
Reset (async, rst=1):
- state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), timeout counter=0.
- rf_we=0, retire=0, halted=0, fault=0.
- imem_req is forced 0 while rst is high and rises the first cycle after release.

States: FETCH, EXEC, HALT, FAULT.

FETCH:
- Outputs: imem_req=1, imem_addr=pc.
- If imem_ack=1 at a posedge: instr<=imem_rdata, counter<=0, go EXEC.
- Else counter increments; when counter reaches FETCH_TIMEOUT-1 without ack, go FAULT at that edge (FETCH_TIMEOUT cycles total in FETCH).
- An ack on the FETCH_TIMEOUT-th cycle wins over the timeout.

EXEC (exactly one cycle):
- Outputs: rf_we=ctl_rf_we, retire=1, imem_req=0.
- If pc==last_pc: go HALT, pc unchanged.
- Else pc<=pc+1 (32-bit wrap, 32'hFFFF_FFFF -> 0), go FETCH.

HALT:
- Outputs: halted=1, imem_req=0, rf_we=0.
- Only rst exits.

FAULT:
- Outputs: fault=1, imem_req=0, rf_we=0.
- Only rst exits; pc holds the faulting address.

General:
- rf_we and retire are 0 in every state except EXEC.
- imem_ack outside FETCH is ignored.
- Minimum throughput: 2 cycles per instruction (ack in first FETCH cycle).
- Latency from ack to rf_we: 1 cycle.
- instr is stable from EXEC through the next ack, so decode stays valid through EXEC.
- Reset mid-fetch or mid-execute aborts immediately; no partial write is issued.
- last_pc is sampled only in EXEC; changing it elsewhere has no effect on the current step.

Optional Feature:
CORE_SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] (increments every cycle out of reset, including HALT/FAULT) and instret[31:0] (increments on retire).
  - Both counters cleared by rst and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Program of 4 words at addr 0..3, last_pc=3, ack same cycle as req:
  - Required: retire pulses at cycles 2,4,6,8 after reset release.
  - Required: pc sequence 0,1,2,3; halted=1 from cycle 9; imem_req stays 0 after.
- Ack delayed 3 cycles per fetch:
  - Required: imem_req held with constant imem_addr until ack.
  - Required: 5 cycles per instruction; instr equals the acked imem_rdata.
- FETCH_TIMEOUT=16, never ack:
  - Required: fault=1 after exactly 16 FETCH cycles; pc=RESET_PC; rf_we and retire never asserted.
- ctl_rf_we tied 1:
  - Required: rf_we high only in EXEC cycles, never during FETCH, HALT or FAULT.
- RESET_PC=32'hFFFF_FFFF, last_pc=0:
  - Required: executes at FFFF_FFFF, wraps to 0, halts after second retire.
- rst asserted mid-FETCH with imem_ack=1 on the same edge:
  - Required: instr=NOP, pc=RESET_PC, imem_req=0 immediately.
  - Required: with CORE_SEQ_PERF_CNT_EN, cycle_cnt and instret read 0.
